// File: rtl/sa_sequencer.sv
// sa_sequencer: job sequencer for one N x N systolic array.
// A start pulse loads N weight rows, streams LEN skewed input vectors,
// drains the array and returns a one-cycle done pulse.
// Optional feature macro: SA_SEQ_PERF_EN builds the perf_cycles counter;
// without it perf_cycles is tied to 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; in_base latched on accept
// LOAD_W | N cycles of weight-row load strobes, w_row = 0..N-1
// FEED   | LEN+N-1 cycles; rd_en for the first LEN, skewed feed_en follows
// DRAIN  | 2N-1 cycles with all strobes low while the array empties
// DONE   | single cycle, done=1
module sa_sequencer #(
  parameter int N      = 3,
  parameter int LEN    = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] in_base,
  output logic              w_load,
  output logic [2:0]        w_row,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [N-1:0]      feed_en,
  output logic              busy,
  output logic              done,
  output logic [15:0]       perf_cycles
);

  // Wide enough for LEN+N-2 at the largest legal N and LEN.
  localparam int TMR_W = 9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOADW = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [TMR_W-1:0] LOAD_LAST  = TMR_W'(N - 1);
  localparam logic [TMR_W-1:0] FEED_LAST  = TMR_W'(LEN + N - 2);
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(2 * N - 2);
  localparam logic [TMR_W-1:0] RD_MIN     = TMR_W'(N - 1);

  logic [2:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0]      feed_en_q, feed_en_d;
  logic [TMR_W-1:0]  t_feed;

  // Timers count down to zero; the FEED index t is recovered from the timer.
  assign t_feed = FEED_LAST - tmr_q;

  // Next-state, phase timer and read-address sequencing.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOADW;
          tmr_d   = LOAD_LAST;
          addr_d  = in_base;
        end
      end
      S_LOADW: begin
        if (tmr_q == '0) begin
          state_d = S_FEED;
          tmr_d   = FEED_LAST;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_FEED: begin
        addr_d = addr_q + ADDR_W'(1);
        if (tmr_q == '0) begin
          state_d = S_DRAIN;
          tmr_d   = DRAIN_LAST;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_DRAIN: begin
        if (tmr_q == '0) begin
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
    // A busy-state abort beats everything, including a simultaneous start.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tmr_d   = '0;
    end
  end

  // Row r is enabled for FEED indices r..r+LEN-1; registered so it lines up
  // with the input-buffer read data, which arrives one cycle after rd_en.
  always_comb begin
    feed_en_d = '0;
    for (int r = 0; r < N; r++) begin
      feed_en_d[r] = (state_q == S_FEED) && !abort &&
                     (t_feed >= TMR_W'(r)) && (t_feed < TMR_W'(r + LEN));
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      addr_q    <= '0;
      feed_en_q <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      addr_q    <= addr_d;
      feed_en_q <= feed_en_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign w_load  = (state_q == S_LOADW);
  assign w_row   = (state_q == S_LOADW) ? 3'(LOAD_LAST - tmr_q) : 3'd0;
  assign rd_en   = (state_q == S_FEED) && (tmr_q >= RD_MIN);
  assign rd_addr = (state_q == S_FEED) ? addr_q : '0;
  assign feed_en = feed_en_q;

`ifdef SA_SEQ_PERF_EN
  logic [15:0] perf_cnt_q;
  logic [15:0] perf_q;

  // Count busy cycles of the running job; publish the total as DONE ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        perf_cnt_q <= '0;
      end else if (busy) begin
        perf_cnt_q <= perf_cnt_q + 16'd1;
      end
      if ((state_q == S_DONE) && !abort) begin
        perf_q <= perf_cnt_q + 16'd1;
      end
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sa_sequencer.sv
// Testbench for sa_sequencer: two instances (N=3/LEN=4 and N=2/LEN=3)
// checked cycle by cycle against a timing model derived from job-relative
// cycle numbers.
module tb_sa_sequencer;

  localparam int NA = 3;
  localparam int LA = 4;
  localparam int NB = 2;
  localparam int LB = 3;
`ifdef SA_SEQ_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] perf;
    logic        busy;
    logic        done;
    logic        w_load;
    logic [2:0]  w_row;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [7:0]  feed_en;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       start;
  logic       abort;
  logic [7:0] base;

  logic        w_load_a, rd_en_a, busy_a, done_a;
  logic [2:0]  w_row_a;
  logic [7:0]  rd_addr_a;
  logic [2:0]  feed_en_a;
  logic [15:0] perf_a;
  logic        w_load_b, rd_en_b, busy_b, done_b;
  logic [2:0]  w_row_b;
  logic [7:0]  rd_addr_b;
  logic [1:0]  feed_en_b;
  logic [15:0] perf_b;

  logic start_a, start_b, abort_a, abort_b;
  assign start_a = start & ~sel;
  assign abort_a = abort & ~sel;
  assign start_b = start & sel;
  assign abort_b = abort & sel;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] perf_exp [2];
  obs_t        obs;

  always #5 clk = ~clk;

  sa_sequencer #(.N(NA), .LEN(LA), .ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .in_base(base),
    .w_load(w_load_a), .w_row(w_row_a), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .feed_en(feed_en_a), .busy(busy_a), .done(done_a), .perf_cycles(perf_a)
  );

  sa_sequencer #(.N(NB), .LEN(LB), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .in_base(base),
    .w_load(w_load_b), .w_row(w_row_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .feed_en(feed_en_b), .busy(busy_b), .done(done_b), .perf_cycles(perf_b)
  );

  always_comb begin
    obs = '0;
    if (!sel) begin
      obs.perf = perf_a; obs.busy = busy_a; obs.done = done_a;
      obs.w_load = w_load_a; obs.w_row = w_row_a; obs.rd_en = rd_en_a;
      obs.rd_addr = rd_addr_a; obs.feed_en[2:0] = feed_en_a;
    end else begin
      obs.perf = perf_b; obs.busy = busy_b; obs.done = done_b;
      obs.w_load = w_load_b; obs.w_row = w_row_b; obs.rd_en = rd_en_b;
      obs.rd_addr = rd_addr_b; obs.feed_en[1:0] = feed_en_b;
    end
  end

  function automatic int n_of(input logic s);
    return s ? NB : NA;
  endfunction

  function automatic int len_of(input logic s);
    return s ? LB : LA;
  endfunction

  // Expected outputs in cycle k after the accept edge (perf filled by caller).
  function automatic obs_t model(input int k, input int n, input int len,
                                 input logic [7:0] b);
    obs_t e;
    int   t;
    int   tp;
    e = '0;
    if (k >= 1 && k <= 4 * n + len - 1) begin
      e.busy = 1'b1;
      e.done = (k == 4 * n + len - 1);
      if (k <= n) begin
        e.w_load = 1'b1;
        e.w_row  = 3'(k - 1);
      end
      t = k - n - 1;
      if (t >= 0 && t < len) begin
        e.rd_en   = 1'b1;
        e.rd_addr = b + 8'(t);
      end
      tp = k - n - 2;
      for (int r = 0; r < n; r++) begin
        if (tp >= r && tp < r + len) e.feed_en[r] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      n_vec++;
      if (obs !== obs_t'(0)) begin
        n_err++;
        $display("FAIL reset_held dut=%0d got=%h want=0", i, obs);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      n_vec++;
      if (obs !== obs_t'(0)) begin
        n_err++;
        $display("FAIL reset_released dut=%0d got=%h want=0", i, obs);
      end
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  // One job on the selected DUT. abort_at: -1 none, 0 together with the
  // accepted start, k>=1 during busy cycle k. spur_at: extra start in cycle k.
  task automatic test_job(input logic s, input logic [7:0] b, input int abort_at,
                          input int spur_at, input string tag);
    int          n;
    int          len;
    int          p;
    logic [15:0] perf_old;
    obs_t        e;
    obs_t        g;
    sel      = s;
    n        = n_of(s);
    len      = len_of(s);
    p        = 4 * n + len;
    perf_old = perf_exp[s];
    e        = '0;
    start    = 1'b1;
    base     = b;
    abort    = (abort_at == 0);
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= p; k++) begin
      start = (k == spur_at);
      abort = (k == abort_at);
      e = model(k, n, len, b);
      if (abort_at >= 1 && k > abort_at) e = '0;
      e.perf = perf_old;
      if (k == p && abort_at < 1 && PERF_ON) e.perf = 16'(p - 1);
      g = obs;
      if (!e.rd_en) g.rd_addr = '0;
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL job_%s k=%0d got=%h want=%h", tag, k, g, e);
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    perf_exp[s] = e.perf;
  endtask

  task automatic test_back_to_back();
    int          n;
    int          len;
    int          p;
    int          last_done;
    logic [7:0]  b;
    logic [15:0] perf_old;
    obs_t        e;
    obs_t        g;
    sel       = 1'b0;
    n         = NA;
    len       = LA;
    p         = 4 * n + len;
    b         = 8'($urandom_range(0, 255));
    perf_old  = perf_exp[0];
    last_done = -1;
    base      = b;
    abort     = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 2 * p; k++) begin
      if (k == p + 1) start = 1'b0;
      e = (k <= p) ? model(k, n, len, b) : model(k - p, n, len, b);
      e.perf = (k >= p && PERF_ON) ? 16'(p - 1) : perf_old;
      g = obs;
      if (!e.rd_en) g.rd_addr = '0;
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL back_to_back k=%0d got=%h want=%h", k, g, e);
      end
      if (obs.done) begin
        if (last_done >= 0) begin
          n_vec++;
          if (k - last_done !== p) begin
            n_err++;
            $display("FAIL done_gap got=%0d want=%0d", k - last_done, p);
          end
        end
        last_done = k;
      end
      @(negedge clk);
    end
    start = 1'b0;
    perf_exp[0] = e.perf;
  endtask

  task automatic test_async_reset();
    sel   = 1'b0;
    base  = 8'h5A;
    abort = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (NA + 1) @(negedge clk);
    n_vec++;
    if (obs.busy !== 1'b1 || obs.rd_en !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_feed busy=%b rd_en=%b want 1 1", obs.busy, obs.rd_en);
    end
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #0.1;
      n_vec++;
      if (obs !== obs_t'(0)) begin
        n_err++;
        $display("FAIL async_reset dut=%0d got=%h want=0", i, obs);
      end
    end
    perf_exp[0] = '0;
    perf_exp[1] = '0;
    sel = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_job(1'b0, 8'($urandom_range(0, 255)), -1, -1, "after_reset");
  endtask

  task automatic test_random();
    logic s;
    int   p;
    int   ab;
    int   sp;
    for (int it = 0; it < 24; it++) begin
      s  = 1'($urandom_range(0, 1));
      p  = 4 * n_of(s) + len_of(s);
      ab = -1;
      case ($urandom_range(0, 3))
        0: ab = $urandom_range(1, p - 1);
        1: ab = 0;
        default: ab = -1;
      endcase
      sp = -1;
      if ($urandom_range(0, 1) == 1) sp = $urandom_range(1, (ab >= 1) ? ab : p - 1);
      test_job(s, 8'($urandom_range(0, 255)), ab, sp, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    reset       = 1'b0;
    sel         = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    base        = '0;
    perf_exp[0] = '0;
    perf_exp[1] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_job(1'b0, 8'h10, -1, -1, "basic_n3");
    test_job(1'b1, 8'hFE, -1, -1, "wrap_n2");
    test_job(1'b0, 8'h20, 6, -1, "abort_c6");
    test_job(1'b0, 8'h33, 0, -1, "start_wins_idle");
    test_job(1'b1, 8'h40, 2, 2, "abort_wins_busy");
    test_job(1'b0, 8'h70, -1, 5, "start_ignored");
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
